karatsuba_mac_accum: RTL and testbench
======================================

// Module: karatsuba_mac_accum
// PURPOSE
//  Downstream consumer of karatsuba64: sums a sequence of 128-bit products into a wide accumulator (dot product).
//  karatsuba64 has no handshake, so this block tracks operand issue with a latency-matched tag line.
//  Releases one sum per sequence over a valid/ready output; only one sequence is in flight at a time.
// PARAMETERS
//  MULT_LATENCY  1    clocks from x/y applied to karatsuba64 until its product is valid (>=1)
//  ACC_W         136  accumulator width; 128 + 8 guard bits covers 256 full-scale terms
//  MAX_TERMS     256  terms per sequence; the term at count MAX_TERMS-1 is forced last
// PORTS
//  clk        in   1      system clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      x/y driven to karatsuba64 this cycle; term accepted iff in_valid && in_ready
//  in_last    in   1      accepted term ends its sequence
//  in_ready   out  1      block can accept a term this cycle
//  product    in   128    karatsuba64 product output
//  out_valid  out  1      acc_out holds a completed sum
//  out_ready  in   1      consumer takes the sum when out_valid && out_ready
//  acc_out    out  ACC_W  completed sum, stable while out_valid=1
//  overflow   out  1      carry out of ACC_W during the current or held sequence (sticky)
//  term_cnt   out  16     terms accepted in the current sequence
// BEHAVIOUR
//  Reset: in_ready=1, out_valid=0, acc_out=0, overflow=0, term_cnt=0, accumulator=0, all tags=0, state=ACCUM.
//  Tag line:
//   - MULT_LATENCY-stage shift register of {valid,last}, loaded with {accept,last_eff}.
//   - last_eff = in_last || (term_cnt == MAX_TERMS-1).
//   - A product is used only on an edge where the output tag is valid; untagged products are ignored.
//  Timing: term accepted at edge t is added at edge t+MULT_LATENCY.
//   - Last term accepted at edge t: out_valid rises at edge t+MULT_LATENCY+1.
//  FSM ACCUM -> DRAIN -> HOLD -> ACCUM:
//   - ACCUM: in_ready=1. term_cnt increments on each accept. Accept with last_eff -> DRAIN; term_cnt holds.
//   - DRAIN: in_ready=0. Tagged products are still added. Tag with last seen -> latch acc_out = acc + product,
//     clear the accumulator, go to HOLD.
//   - HOLD: in_ready=0, out_valid=1. On out_valid && out_ready -> ACCUM; out_valid=0, term_cnt=0, overflow=0 at that edge.
//  Arithmetic:
//   - acc_next = acc + {{(ACC_W-128){1'b0}}, product} (unsigned).
//   - Carry out of bit ACC_W-1 sets overflow.
//   - The result wraps modulo 2^ACC_W unless KMAC_SATURATE_EN is defined.
//  Boundaries:
//   - in_valid while in_ready=0 is ignored: no tag, no count.
//   - Single-term sequence (first term has in_last=1) is legal.
//   - MULT_LATENCY=1: ACCUM->DRAIN->HOLD takes exactly 2 edges.
//   - out_ready high in the same cycle out_valid rises: sum taken at the next edge; in_ready=1 one cycle later.
//   - in_valid=0 gaps within a sequence are legal; the accumulator holds.
//   - Reset mid-sequence or mid-HOLD: everything returns to reset values; in-flight products are discarded.
// CONFIGURATION
//  KMAC_SATURATE_EN:
//   - Defined: an add that carries out clamps the accumulator to all-ones; later adds keep it all-ones until cleared.
//     overflow is still set.
//   - Undefined: the accumulator wraps.
// STRUCTURE
//  kmac_pkg:
//   - state encoding localparams ST_ACCUM/ST_DRAIN/ST_HOLD;
//   - PROD_W=128, CNT_W=16;
//   - widening helper for the ACC_W zero-extend.
//  Sub-module kmac_tag_pipe: parameterised {valid,last} delay line with async reset.
//   - Reused wherever a stage must shadow karatsuba64's latency.
// TESTING (bench drives karatsuba64 + this block; MULT_LATENCY=1 unless stated)
//  1. 3 terms (2*3, 4*5, 6*7), last on the 3rd, out_ready=1 -> acc_out=68, overflow=0, term_cnt=3;
//     out_valid is high for exactly 1 cycle, 2 edges after the last accept.
//  2. Single term x=y=64'hFFFF_FFFF_FFFF_FFFF, last=1 -> acc_out=128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001.
//  3. out_ready=0 for 5 cycles after the sum -> out_valid and acc_out stable; in_ready=0; in_valid pulses
//     ignored (term_cnt unchanged); release -> in_ready=1 one cycle later.
//  4. ACC_W=129, three full-scale terms (2^128-1 each) -> overflow=1;
//     wrap build: acc_out=2^128-3 mod 2^129; KMAC_SATURATE_EN build: acc_out=all-ones.
//  5. MAX_TERMS=4, 6 terms of 1*1 with no in_last -> 4th term forced last, acc_out=4;
//     next sequence starts cleanly (terms 5-6 -> acc_out=2 with last on term 6).
//  6. rst_n low for 1 cycle while in DRAIN with MULT_LATENCY=3 -> no out_valid; in_ready=1 after release;
//     the next 1-term sequence 9*9 gives 81.

Source files
------------

// File: rtl/kmac_pkg.sv
// Shared types, widths and the product zero-extend helper for the Karatsuba MAC accumulator.
package kmac_pkg;

  localparam int PROD_W = 128;
  localparam int CNT_W  = 16;
  localparam int WIDE_W = 256;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } kmac_state_e;

  // Zero-extend a product to the widest supported accumulator; callers truncate to ACC_W.
  function automatic logic [WIDE_W-1:0] kmac_widen(input logic [PROD_W-1:0] p);
    return {{(WIDE_W-PROD_W){1'b0}}, p};
  endfunction

endpackage

// File: rtl/kmac_tag_pipe.sv
// {valid,last} delay line that shadows the multiplier latency so each product can be matched
// to the term that produced it.
module kmac_tag_pipe #(
  parameter int DEPTH = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_valid,
  input  logic i_last,
  output logic o_valid,
  output logic o_last
);

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_last;

  // Shift the tags one stage per clock.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= {DEPTH{1'b0}};
      r_last  <= {DEPTH{1'b0}};
    end else begin
      r_valid[0] <= i_valid;
      r_last[0]  <= i_last;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_last[i]  <= r_last[i-1];
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_last  = r_last[DEPTH-1];

endmodule

// File: rtl/karatsuba_mac_accum.sv
// Sums a sequence of karatsuba64 products into an ACC_W accumulator and releases one sum per
// sequence over valid/ready. Define KMAC_SATURATE_EN to clamp on carry-out instead of wrapping.
module karatsuba_mac_accum
  import kmac_pkg::*;
#(
  parameter int MULT_LATENCY = 1,
  parameter int ACC_W        = 136,
  parameter int MAX_TERMS    = 256
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_in_valid,
  input  logic              i_in_last,
  output logic              o_in_ready,
  input  logic [PROD_W-1:0] i_product,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [ACC_W-1:0]  o_acc_out,
  output logic              o_overflow,
  output logic [CNT_W-1:0]  o_term_cnt
);

  kmac_state_e      r_state;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_acc_out;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_overflow;
  logic [CNT_W-1:0] r_term_cnt;

  logic             w_accept;
  logic             w_last_eff;
  logic             w_tag_valid;
  logic             w_tag_last;
  logic [ACC_W-1:0] w_prod_ext;
  logic [ACC_W:0]   w_sum;
  logic             w_carry;
  logic [ACC_W-1:0] w_acc_next;

  assign w_accept   = i_in_valid & r_in_ready;
  assign w_last_eff = i_in_last | (r_term_cnt == CNT_W'(MAX_TERMS - 1));

  kmac_tag_pipe #(
    .DEPTH(MULT_LATENCY)
  ) u_tag_pipe (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_valid(w_accept),
    .i_last (w_accept & w_last_eff),
    .o_valid(w_tag_valid),
    .o_last (w_tag_last)
  );

  assign w_prod_ext = ACC_W'(kmac_widen(i_product));
  assign w_sum      = {1'b0, r_acc} + {1'b0, w_prod_ext};
  assign w_carry    = w_sum[ACC_W];

`ifdef KMAC_SATURATE_EN
  // Once clamped, any further non-zero add carries again, so the value sticks at all-ones.
  assign w_acc_next = w_carry ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
  assign w_acc_next = w_sum[ACC_W-1:0];
`endif

  // Sequence FSM, accumulator and registered handshake outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_ACCUM;
      r_acc       <= {ACC_W{1'b0}};
      r_acc_out   <= {ACC_W{1'b0}};
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
      r_term_cnt  <= 16'd0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (w_tag_valid) begin
            r_acc <= w_acc_next;
            if (w_carry) r_overflow <= 1'b1;
          end
          if (w_accept) begin
            r_term_cnt <= r_term_cnt + 16'd1;
            if (w_last_eff) begin
              r_state    <= ST_DRAIN;
              r_in_ready <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          if (w_tag_valid) begin
            if (w_carry) r_overflow <= 1'b1;
            if (w_tag_last) begin
              r_acc_out <= w_acc_next;
              r_acc     <= {ACC_W{1'b0}};
              r_state   <= ST_HOLD;
            end else begin
              r_acc <= w_acc_next;
            end
          end
        end
        ST_HOLD: begin
          // out_valid trails HOLD entry by one edge; the sum is only handed over once it is visible.
          if (r_out_valid && i_out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_ACCUM;
            r_in_ready  <= 1'b1;
            r_term_cnt  <= 16'd0;
            r_overflow  <= 1'b0;
          end else begin
            r_out_valid <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_ACCUM;
          r_acc       <= {ACC_W{1'b0}};
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_term_cnt  <= 16'd0;
          r_overflow  <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_acc_out   = r_acc_out;
  assign o_overflow  = r_overflow;
  assign o_term_cnt  = r_term_cnt;

endmodule

// File: tb/tb_karatsuba_mac_accum.sv
// Self-checking bench: four accumulator instances (default, ACC_W=129, MAX_TERMS=4,
// MULT_LATENCY=3) each fed by a behavioural karatsuba64 stand-in delay line.
module tb_karatsuba_mac_accum;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         in_valid[4];
  logic         in_last[4];
  logic         out_ready[4];
  logic [127:0] kin[4];
  logic [127:0] prod[4];
  logic [127:0] p3a, p3b;

  logic         in_ready[4];
  logic         out_valid[4];
  logic         ovf[4];
  logic [15:0]  tcnt[4];
  logic [135:0] acc0, acc2, acc3;
  logic [128:0] acc1;

  int n_checks = 0;
  int n_pass   = 0;

  // Multiplier stand-in: product of the operands applied in a cycle appears MULT_LATENCY clocks later.
  always @(posedge clk) begin
    prod[0] <= kin[0];
    prod[1] <= kin[1];
    prod[2] <= kin[2];
    p3a     <= kin[3];
    p3b     <= p3a;
    prod[3] <= p3b;
  end

  karatsuba_mac_accum u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid[0]), .i_in_last(in_last[0]),
    .o_in_ready(in_ready[0]), .i_product(prod[0]), .o_out_valid(out_valid[0]),
    .i_out_ready(out_ready[0]), .o_acc_out(acc0), .o_overflow(ovf[0]), .o_term_cnt(tcnt[0]));

  karatsuba_mac_accum #(.ACC_W(129)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid[1]), .i_in_last(in_last[1]),
    .o_in_ready(in_ready[1]), .i_product(prod[1]), .o_out_valid(out_valid[1]),
    .i_out_ready(out_ready[1]), .o_acc_out(acc1), .o_overflow(ovf[1]), .o_term_cnt(tcnt[1]));

  karatsuba_mac_accum #(.MAX_TERMS(4)) u2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid[2]), .i_in_last(in_last[2]),
    .o_in_ready(in_ready[2]), .i_product(prod[2]), .o_out_valid(out_valid[2]),
    .i_out_ready(out_ready[2]), .o_acc_out(acc2), .o_overflow(ovf[2]), .o_term_cnt(tcnt[2]));

  karatsuba_mac_accum #(.MULT_LATENCY(3)) u3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid[3]), .i_in_last(in_last[3]),
    .o_in_ready(in_ready[3]), .i_product(prod[3]), .o_out_valid(out_valid[3]),
    .i_out_ready(out_ready[3]), .o_acc_out(acc3), .o_overflow(ovf[3]), .o_term_cnt(tcnt[3]));

  function automatic logic [127:0] mul(input logic [63:0] a, input logic [63:0] b);
    return {64'd0, a} * {64'd0, b};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for in_ready, then present one term for exactly one edge.
  task automatic send(input int i, input logic [127:0] p, input logic last);
    int n;
    n = 0;
    while (!in_ready[i] && n < 100) begin
      step();
      n++;
    end
    n_checks++;
    if (in_ready[i] !== 1'b1)
      $display("FAIL send_ready inst%0d: in_ready=%b expected 1 within 100 cycles", i, in_ready[i]);
    else
      n_pass++;
    in_valid[i] = 1'b1;
    in_last[i]  = last;
    kin[i]      = p;
    step();
    in_valid[i] = 1'b0;
    in_last[i]  = 1'b0;
    kin[i]      = rand128();
  endtask

  task automatic wait_out(input int i, input string name);
    int n;
    n = 0;
    while (!out_valid[i] && n < 60) begin
      step();
      n++;
    end
    n_checks++;
    if (out_valid[i] !== 1'b1)
      $display("FAIL %s_timeout: out_valid=%b expected 1 within 60 cycles", name, out_valid[i]);
    else
      n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid[i] = 1'b0; in_last[i] = 1'b0; out_ready[i] = 1'b0; kin[i] = rand128();
    end
    step(); step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (in_ready[i] !== 1'b1 || out_valid[i] !== 1'b0 || ovf[i] !== 1'b0 || tcnt[i] !== 16'd0)
        $display("FAIL reset inst%0d: rdy=%b vld=%b ovf=%b cnt=%0d expected 1 0 0 0",
                 i, in_ready[i], out_valid[i], ovf[i], tcnt[i]);
      else
        n_pass++;
    end
    n_checks++;
    if (acc0 !== 136'd0 || acc1 !== 129'd0 || acc2 !== 136'd0 || acc3 !== 136'd0)
      $display("FAIL reset_acc: acc0=%0h acc1=%0h acc2=%0h acc3=%0h expected 0", acc0, acc1, acc2, acc3);
    else
      n_pass++;
  endtask

  task automatic test_three_terms();
    out_ready[0] = 1'b1;
    send(0, mul(64'd2, 64'd3), 1'b0);
    send(0, mul(64'd4, 64'd5), 1'b0);
    send(0, mul(64'd6, 64'd7), 1'b1);
    n_checks++;
    if (in_ready[0] !== 1'b0) $display("FAIL t1_drain_rdy: in_ready=%b expected 0", in_ready[0]);
    else n_pass++;
    step();
    n_checks++;
    if (out_valid[0] !== 1'b0) $display("FAIL t1_early: out_valid=%b expected 0 one edge after last", out_valid[0]);
    else n_pass++;
    step();
    n_checks++;
    if (out_valid[0] !== 1'b1 || acc0 !== 136'd68 || ovf[0] !== 1'b0 || tcnt[0] !== 16'd3)
      $display("FAIL t1_sum: vld=%b acc=%0d ovf=%b cnt=%0d expected 1 68 0 3", out_valid[0], acc0, ovf[0], tcnt[0]);
    else n_pass++;
    step();
    n_checks++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || tcnt[0] !== 16'd0)
      $display("FAIL t1_after: vld=%b rdy=%b cnt=%0d expected 0 1 0", out_valid[0], in_ready[0], tcnt[0]);
    else n_pass++;
  endtask

  task automatic test_full_scale_single();
    logic [135:0] exp;
    exp = {8'h00, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001};
    send(0, mul(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF), 1'b1);
    wait_out(0, "t2");
    n_checks++;
    if (acc0 !== exp || tcnt[0] !== 16'd1 || ovf[0] !== 1'b0)
      $display("FAIL t2_sum: acc=%0h cnt=%0d ovf=%b expected %0h 1 0", acc0, tcnt[0], ovf[0], exp);
    else n_pass++;
    step();
  endtask

  task automatic test_backpressure();
    logic [63:0]  x, y;
    logic [255:0] s;
    s = 256'd0;
    out_ready[0] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      x = {$urandom(), $urandom()};
      y = {$urandom(), $urandom()};
      s = s + {128'd0, mul(x, y)};
      send(0, mul(x, y), k == 1);
    end
    wait_out(0, "t3");
    for (int c = 0; c < 5; c++) begin
      in_valid[0] = 1'b1;
      in_last[0]  = c[0];
      step();
      n_checks++;
      if (out_valid[0] !== 1'b1 || acc0 !== s[135:0] || in_ready[0] !== 1'b0 || tcnt[0] !== 16'd2)
        $display("FAIL t3_hold c%0d: vld=%b acc=%0h rdy=%b cnt=%0d expected 1 %0h 0 2",
                 c, out_valid[0], acc0, in_ready[0], tcnt[0], s[135:0]);
      else n_pass++;
    end
    in_valid[0]  = 1'b0;
    in_last[0]   = 1'b0;
    out_ready[0] = 1'b1;
    step();
    n_checks++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || tcnt[0] !== 16'd0)
      $display("FAIL t3_release: vld=%b rdy=%b cnt=%0d expected 0 1 0", out_valid[0], in_ready[0], tcnt[0]);
    else n_pass++;
  endtask

  task automatic test_overflow();
    logic [127:0] fs;
    logic [255:0] s;
    logic [128:0] exp;
    fs = {128{1'b1}};
    s  = 256'd3 * {128'd0, fs};
`ifdef KMAC_SATURATE_EN
    exp = {129{1'b1}};
`else
    exp = s[128:0];
`endif
    out_ready[1] = 1'b1;
    send(1, fs, 1'b0);
    send(1, fs, 1'b0);
    send(1, fs, 1'b1);
    wait_out(1, "t4");
    n_checks++;
    if (ovf[1] !== 1'b1 || acc1 !== exp)
      $display("FAIL t4_ovf: ovf=%b acc=%0h expected 1 %0h", ovf[1], acc1, exp);
    else n_pass++;
    step();
    n_checks++;
    if (ovf[1] !== 1'b0) $display("FAIL t4_ovf_clear: ovf=%b expected 0", ovf[1]);
    else n_pass++;
  endtask

  task automatic test_max_terms();
    out_ready[2] = 1'b1;
    for (int k = 0; k < 4; k++) send(2, mul(64'd1, 64'd1), 1'b0);
    n_checks++;
    if (in_ready[2] !== 1'b0 || tcnt[2] !== 16'd4)
      $display("FAIL t5_forced: rdy=%b cnt=%0d expected 0 4", in_ready[2], tcnt[2]);
    else n_pass++;
    wait_out(2, "t5a");
    n_checks++;
    if (acc2 !== 136'd4) $display("FAIL t5_sum4: acc=%0d expected 4", acc2);
    else n_pass++;
    step();
    send(2, mul(64'd1, 64'd1), 1'b0);
    send(2, mul(64'd1, 64'd1), 1'b1);
    wait_out(2, "t5b");
    n_checks++;
    if (acc2 !== 136'd2 || tcnt[2] !== 16'd2)
      $display("FAIL t5_sum2: acc=%0d cnt=%0d expected 2 2", acc2, tcnt[2]);
    else n_pass++;
    step();
  endtask

  task automatic test_random();
    logic [63:0]  x, y;
    logic [255:0] s;
    int           len;
    for (int q = 0; q < 6; q++) begin
      len = $urandom_range(1, 6);
      s   = 256'd0;
      out_ready[0] = $urandom_range(0, 1) == 1;
      for (int k = 0; k < len; k++) begin
        x = {$urandom(), $urandom()};
        y = {$urandom(), $urandom()};
        s = s + {128'd0, mul(x, y)};
        repeat ($urandom_range(0, 2)) step();
        send(0, mul(x, y), k == len - 1);
      end
      wait_out(0, "rnd");
      n_checks++;
      if (acc0 !== s[135:0] || ovf[0] !== 1'b0 || tcnt[0] !== 16'(len))
        $display("FAIL rnd_sum q%0d: acc=%0h ovf=%b cnt=%0d expected %0h 0 %0d", q, acc0, ovf[0], tcnt[0], s[135:0], len);
      else n_pass++;
      repeat ($urandom_range(0, 3)) step();
      out_ready[0] = 1'b1;
      step();
      n_checks++;
      if (out_valid[0] !== 1'b0) $display("FAIL rnd_taken q%0d: out_valid=%b expected 0", q, out_valid[0]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_in_drain();
    int seen;
    out_ready[3] = 1'b1;
    send(3, mul(64'd5, 64'd5), 1'b0);
    send(3, mul(64'd7, 64'd7), 1'b1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_checks++;
    if (in_ready[3] !== 1'b1 || out_valid[3] !== 1'b0 || tcnt[3] !== 16'd0)
      $display("FAIL t6_reset: rdy=%b vld=%b cnt=%0d expected 1 0 0", in_ready[3], out_valid[3], tcnt[3]);
    else n_pass++;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (out_valid[3] === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) $display("FAIL t6_no_out: out_valid cycles=%0d expected 0", seen);
    else n_pass++;
    send(3, mul(64'd9, 64'd9), 1'b1);
    wait_out(3, "t6");
    n_checks++;
    if (acc3 !== 136'd81 || tcnt[3] !== 16'd1 || ovf[3] !== 1'b0)
      $display("FAIL t6_sum: acc=%0d cnt=%0d ovf=%b expected 81 1 0", acc3, tcnt[3], ovf[3]);
    else n_pass++;
    step();
  endtask

  initial begin
    test_reset();
    test_three_terms();
    test_full_scale_single();
    test_backpressure();
    test_overflow();
    test_max_terms();
    test_random();
    test_reset_in_drain();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
